// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI4 read-channel arbiter.
// Optional build macro used by the arbiter: AXI_ARB_ROUND_ROBIN_EN.
package axi_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // AXI RRESP encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ID 0 is never issued, so the slave ID for master idx is idx+1
  function automatic int unsigned idx_to_id(input int unsigned idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_picker.sv
// Combinational request picker: scans the request vector starting at ptr and
// grants the first requester found. With ptr tied to zero this degenerates to
// fixed priority (lowest index wins).
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned cand;

  // Circular search from ptr; the first hit locks out later candidates
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = (32'(ptr) + 32'(k)) % 32'(N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-master to 1-slave AXI4 read-channel arbiter. One outstanding read; the
// grant is held from AR issue until the last R beat.
// Build macro AXI_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it, fixed priority (lowest index wins) and no pointer register.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        m_arvalid,
  input  logic [N_MASTERS*ADDR_W-1:0] m_araddr,
  output logic [N_MASTERS-1:0]        m_arready,
  output logic [N_MASTERS-1:0]        m_rvalid,
  input  logic [N_MASTERS-1:0]        m_rready,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [1:0]                  m_rresp,
  output logic                        m_rlast,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  output logic [ADDR_W-1:0]           s_araddr,
  output logic [ID_W-1:0]             s_arid,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  input  logic [DATA_W-1:0]           s_rdata,
  input  logic [1:0]                  s_rresp,
  input  logic                        s_rlast,
  input  logic [ID_W-1:0]             s_rid,
  output logic                        id_err
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  arb_state_e             state_q, state_d;
  logic [N_MASTERS-1:0]   gnt_q, gnt_d;
  logic                   s_arvalid_q, s_arvalid_d;
  logic [ADDR_W-1:0]      s_araddr_q, s_araddr_d;
  logic [ID_W-1:0]        s_arid_q, s_arid_d;
  logic                   id_err_q, id_err_d;

  logic [IDX_W-1:0]       ptr;
  logic [N_MASTERS-1:0]   pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [ADDR_W-1:0]      pick_addr;
  logic                   r_beat;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]       ptr_q, ptr_d;

  // Pointer moves to the slot after the winner on every new grant, wrapping at N_MASTERS-1
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && pick_any) begin
      if (pick_idx == IDX_W'(N_MASTERS - 1)) ptr_d = '0;
      else                                   ptr_d = pick_idx + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  rr_picker #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (m_arvalid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // One-hot AND-OR mux of the winning master's address
  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (pick_gnt[i]) pick_addr = pick_addr | m_araddr[i*ADDR_W +: ADDR_W];
    end
  end

  assign r_beat = (state_q == DATA) && s_rvalid && s_rready;

  // FSM next-state: grant in IDLE, hold AR in ADDR, route R until the last beat in DATA
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    s_arvalid_d = s_arvalid_q;
    s_araddr_d  = s_araddr_q;
    s_arid_d    = s_arid_q;
    id_err_d    = id_err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d       = pick_gnt;
          s_araddr_d  = pick_addr;
          s_arid_d    = ID_W'(idx_to_id(32'(pick_idx)));
          s_arvalid_d = 1'b1;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (s_arready) begin
          s_arvalid_d = 1'b0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (r_beat) begin
          // A wrong ID is flagged but the beat still goes to the granted master
          if (s_rid != s_arid_q) id_err_d = 1'b1;
          if (s_rlast)           state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered AR-channel outputs; reset may land mid-burst
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      s_arvalid_q <= 1'b0;
      s_araddr_q  <= '0;
      s_arid_q    <= '0;
      id_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      s_arvalid_q <= s_arvalid_d;
      s_araddr_q  <= s_araddr_d;
      s_arid_q    <= s_arid_d;
      id_err_q    <= id_err_d;
    end
  end

  // Handshake steering to and from the granted master only
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    s_rready  = 1'b0;
    if (state_q == ADDR && s_arready) m_arready = gnt_q;
    if (state_q == DATA) begin
      if (s_rvalid) m_rvalid = gnt_q;
      s_rready = |(m_rready & gnt_q);
    end
  end

  assign s_arvalid = s_arvalid_q;
  assign s_araddr  = s_araddr_q;
  assign s_arid    = s_arid_q;
  assign id_err    = id_err_q;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter (4 masters). Works with or without
// AXI_ARB_ROUND_ROBIN_EN; the reference picks the winner accordingly.
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [N-1:0]    m_arvalid = '0;
  logic [N*AW-1:0] m_araddr = '0;
  logic [N-1:0]    m_arready;
  logic [N-1:0]    m_rvalid;
  logic [N-1:0]    m_rready = '0;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            s_arvalid;
  logic            s_arready = 1'b0;
  logic [AW-1:0]   s_araddr;
  logic [IW-1:0]   s_arid;
  logic            s_rvalid = 1'b0;
  logic            s_rready;
  logic [DW-1:0]   s_rdata = '0;
  logic [1:0]      s_rresp = '0;
  logic            s_rlast = 1'b0;
  logic [IW-1:0]   s_rid = '0;
  logic            id_err;

  axi_rd_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rid(s_rid), .id_err(id_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stimulus knobs and master/slave bench state
  logic [N-1:0]  req_pend = '0;
  logic [N-1:0]  rereq_mask = '0;
  logic [AW-1:0] req_addr [N];
  int            ar_pct = 100, rv_pct = 100, rr_pct = 100;
  int            burst_len = 0;
  int            bad_rid = -1;
  int            sl_beats = 0;
  logic [IW-1:0] sl_id = '0;
  bit            sl_hold = 1'b0;

  // reference model: phase 0 idle, 1 address issued, 2 data
  int            ph = 0, mg = 0, mptr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [IW-1:0] m_id = '0;
  bit            m_err = 1'b0;
  int            gnt_log[$];

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic int pick(input logic [N-1:0] req, input int ptr);
`ifdef AXI_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
`else
    if (ptr < 0) return -1;
    for (int c = 0; c < N; c++) if (req[c]) return c;
`endif
    return -1;
  endfunction

  task automatic drive_inputs();
    m_arvalid = req_pend;
    for (int i = 0; i < N; i++)
      m_araddr[i*AW +: AW] = req_pend[i] ? req_addr[i] : $urandom;
    s_arready = pct(ar_pct);
    for (int i = 0; i < N; i++) m_rready[i] = pct(rr_pct);
    if (sl_beats > 0) begin
      if (!sl_hold) begin
        s_rvalid = pct(rv_pct);
        s_rdata  = {$urandom, $urandom};
        s_rresp  = $urandom_range(0, 1) ? RESP_SLVERR : RESP_OKAY;
        s_rlast  = (sl_beats == 1);
        s_rid    = (bad_rid >= 0) ? IW'(bad_rid) : sl_id;
      end
    end else begin
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      s_rid    = '0;
    end
  endtask

  task automatic check_and_update();
    logic [N-1:0] exp_arr, exp_rv;
    logic         exp_srr;
    bit           beat, sbeat;
    int           g;
    exp_arr = '0;
    exp_rv  = '0;
    exp_srr = 1'b0;
    if (ph == 1 && s_arready) exp_arr[mg] = 1'b1;
    if (ph == 2 && s_rvalid)  exp_rv[mg]  = 1'b1;
    if (ph == 2)              exp_srr     = m_rready[mg];
    chk("s_arvalid", 64'(s_arvalid), 64'(ph == 1));
    chk("s_araddr",  64'(s_araddr),  64'(m_addr));
    chk("s_arid",    64'(s_arid),    64'(m_id));
    chk("m_arready", 64'(m_arready), 64'(exp_arr));
    chk("m_rvalid",  64'(m_rvalid),  64'(exp_rv));
    chk("s_rready",  64'(s_rready),  64'(exp_srr));
    chk("id_err",    64'(id_err),    64'(m_err));
    if (ph == 2 && s_rvalid) begin
      chk("m_rdata", m_rdata, s_rdata);
      chk("m_rresp", 64'(m_rresp), 64'(s_rresp));
      chk("m_rlast", 64'(m_rlast), 64'(s_rlast));
    end
    sbeat = s_rvalid && s_rready;
    if (rst) begin
      ph = 0; mg = 0; mptr = 0; m_addr = '0; m_id = '0; m_err = 1'b0;
      sl_beats = 0; sl_hold = 1'b0;
    end else begin
      case (ph)
        0: begin
          g = pick(req_pend, mptr);
          if (g >= 0) begin
            mg = g; m_addr = req_addr[g]; m_id = IW'(g + 1);
            mptr = (g + 1) % N;
            ph = 1;
            gnt_log.push_back(g);
          end
        end
        1: begin
          if (s_arready) begin
            ph = 2;
            req_pend[mg] = rereq_mask[mg];
            req_addr[mg] = $urandom;
          end
        end
        default: begin
          beat = s_rvalid && m_rready[mg];
          if (beat && s_rid != IW'(mg + 1)) m_err = 1'b1;
          if (beat && s_rlast) ph = 0;
        end
      endcase
      if (s_arvalid && s_arready) begin
        sl_beats = (burst_len > 0) ? burst_len : int'($urandom_range(1, 4));
        sl_id    = s_arid;
      end else if (sbeat && sl_beats > 0) begin
        sl_beats--;
      end
      sl_hold = s_rvalid && !s_rready && sl_beats > 0;
    end
  endtask

  task automatic step();
    drive_inputs();
    @(negedge clk);
    check_and_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((ph != 0 || req_pend != '0 || sl_beats != 0) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(n < budget), 64'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_pend = '0; rereq_mask = '0; bad_rid = -1;
    step();
    rst = 1'b0;
  endtask

  task automatic collect_grants(input string tag, input int cnt, input int budget);
    int n = 0;
    while (gnt_log.size() < cnt && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(n < budget), 64'(1));
  endtask

  initial begin
    int exp_a [5];
    int exp_b [5];
    int n;
    for (int i = 0; i < N; i++) req_addr[i] = '0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_s_arvalid", 64'(s_arvalid), 64'(0));
    chk("rst_s_arid",    64'(s_arid),    64'(0));
    chk("rst_id_err",    64'(id_err),    64'(0));
    chk("rst_m_arready", 64'(m_arready), 64'(0));
    for (int i = 0; i < 3; i++) step();

    // single master 1, 4-beat burst
    burst_len = 4;
    req_addr[1] = 32'h8000_0010;
    req_pend[1] = 1'b1;
    step();
    chk("single_araddr", 64'(s_araddr), 64'(32'h8000_0010));
    chk("single_arid",   64'(s_arid),   64'(2));
    drain("single_done", 100);

    // AR backpressure for 5 cycles, then R backpressure
    ar_pct = 0;
    req_addr[3] = 32'h1234_5678;
    req_pend[3] = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    chk("bp_arvalid_held", 64'(s_arvalid), 64'(1));
    chk("bp_araddr_held",  64'(s_araddr),  64'(32'h1234_5678));
    ar_pct = 100; rr_pct = 40;
    drain("bp_done", 200);
    rr_pct = 100;

    // masters 0 and 1 requesting back to back
    do_reset();
    gnt_log.delete();
    rereq_mask = 4'b0011;
    req_pend = 4'b0011;
    req_addr[0] = $urandom; req_addr[1] = $urandom;
    collect_grants("pair_grants", 4, 300);
`ifdef AXI_ARB_ROUND_ROBIN_EN
    exp_a = '{0, 1, 0, 1, 0};
`else
    exp_a = '{0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++)
      if (k < gnt_log.size()) chk($sformatf("pair_gnt%0d", k), 64'(gnt_log[k]), 64'(exp_a[k]));
    rereq_mask = '0;
    drain("pair_done", 300);

    // all four requesting continuously
    do_reset();
    gnt_log.delete();
    rereq_mask = 4'b1111;
    req_pend = 4'b1111;
    for (int i = 0; i < N; i++) req_addr[i] = $urandom;
    collect_grants("all_grants", 5, 400);
`ifdef AXI_ARB_ROUND_ROBIN_EN
    exp_b = '{0, 1, 2, 3, 0};
`else
    exp_b = '{0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 5; k++)
      if (k < gnt_log.size()) chk($sformatf("all_gnt%0d", k), 64'(gnt_log[k]), 64'(exp_b[k]));
    rereq_mask = '0;
    drain("all_done", 600);

    // ID mismatch on a grant to master 0
    do_reset();
    burst_len = 2;
    bad_rid = 3;
    req_addr[0] = $urandom;
    req_pend[0] = 1'b1;
    drain("idm_done", 100);
    bad_rid = -1;
    for (int i = 0; i < 3; i++) step();
    chk("idm_sticky", 64'(id_err), 64'(1));
    do_reset();
    chk("idm_cleared", 64'(id_err), 64'(0));

    // reset after two of four beats
    burst_len = 4;
    req_addr[2] = $urandom;
    req_pend[2] = 1'b1;
    n = 0;
    while (!(ph == 2 && sl_beats == 2) && n < 100) begin
      step();
      n++;
    end
    chk("midrst_reach", 64'(n < 100), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_arvalid", 64'(s_arvalid), 64'(0));
    chk("midrst_m_rvalid", 64'(m_rvalid), 64'(0));
    chk("midrst_s_rready", 64'(s_rready), 64'(0));
    chk("midrst_arid", 64'(s_arid), 64'(0));
    req_addr[1] = $urandom;
    req_pend[1] = 1'b1;
    drain("midrst_next", 100);

    // randomized traffic
    burst_len = 0;
    ar_pct = 60; rv_pct = 70; rr_pct = 70;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_pend[i] && pct(12)) begin
          req_pend[i] = 1'b1;
          req_addr[i] = $urandom;
        end
      step();
    end
    ar_pct = 100; rv_pct = 100; rr_pct = 100;
    drain("rand_done", 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name:
axi_rd_arbiter

Overview:
- N-master to 1-slave AXI4 read-channel arbiter; parametrised successor to the two-master IFU/LSU address mux.
- Arbitrates AR requests from N masters (index 0 = IFU, 1 = LSU, others = DMA/debug) and holds the grant for the whole burst.
- Routes the R channel back to the granted master.
- One outstanding read at a time; sits between the core's memory clients and the AXI crossbar/SRAM slave.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 64, read-data width.
- ID_W, 4, AXI ID width; must satisfy 2^ID_W > N_MASTERS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m_arvalid  in  N_MASTERS  per-master AR valid.
- m_araddr  in  N_MASTERS*ADDR_W  per-master address; master i at bits [i*ADDR_W +: ADDR_W].
- m_arready  out  N_MASTERS  per-master AR ready.
- m_rvalid  out  N_MASTERS  per-master R valid.
- m_rready  in  N_MASTERS  per-master R ready.
- m_rdata  out  DATA_W  shared read data, qualified by m_rvalid.
- m_rresp  out  2  shared response.
- m_rlast  out  1  shared last beat.
- s_arvalid  out  1  slave AR valid, registered.
- s_arready  in  1  slave AR ready.
- s_araddr  out  ADDR_W  slave address, registered.
- s_arid  out  ID_W  granted index + 1.
- s_rvalid  in  1  slave R valid.
- s_rready  out  1  slave R ready.
- s_rdata  in  DATA_W  slave read data.
- s_rresp  in  2  slave response.
- s_rlast  in  1  slave last beat.
- s_rid  in  ID_W  slave response ID.
- id_err  out  1  sticky: s_rid mismatched the expected ID.

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Reset: state IDLE; grant 0; priority pointer 0. s_arvalid, s_araddr, s_arid, id_err = 0. All m_arready and m_rvalid = 0; s_rready = 0.
- IDLE, any m_arvalid high in cycle t:
  - Pick winner g by the arbitration policy.
  - Latch m_araddr[g] into s_araddr; set s_arid = g+1 (zero-extended).
  - Set s_arvalid = 1 and enter ADDR at t+1. One cycle of request-to-slave latency.
- ADDR:
  - s_arvalid held with address and ID stable.
  - m_arready[g] = s_arready (combinational); all other m_arready = 0.
  - On s_arvalid & s_arready: clear s_arvalid and enter DATA. Master g's AR handshake completes in the same cycle.
- DATA:
  - m_rvalid[g] = s_rvalid; s_rready = m_rready[g]. m_rdata, m_rresp, m_rlast = s_* passthrough.
  - Every other m_rvalid = 0.
  - On an s_rvalid & s_rready beat where s_rid != g+1: set id_err (sticky until rst). The beat is still routed to g.
  - On an s_rvalid & s_rready & s_rlast beat: enter IDLE. Next grant earliest in the following cycle (one idle cycle between bursts).
- Requests arriving in ADDR or DATA are not accepted; their m_arready stays 0 and they wait.
- A master deasserting m_arvalid before its handshake (protocol violation) does not cancel the issued request; the latched address is used.
- Simultaneous requests: exactly one grant per IDLE cycle; losers retry.
- rst asserted in any state, including mid-burst: return to reset values next edge. In-flight slave data is dropped (s_rready = 0).
- Priority pointer update: on the IDLE to ADDR transition, pointer = (g+1) mod N_MASTERS. Wraps from N_MASTERS-1 to 0.

Optional Feature:
- Macro AXI_ARB_ROUND_ROBIN_EN.
- Defined: round-robin. Search starts at the pointer and the first requesting index wins.
- Undefined: fixed priority, lowest index wins (IFU over LSU, as in the current core). The pointer is not implemented.

Decomposition:
- Shared package axi_arb_pkg holds:
  - FSM state enum {IDLE, ADDR, DATA}.
  - AXI RESP constants (OKAY=2'b00, SLVERR=2'b10).
  - Function idx_to_id(idx) = idx+1.
- One sub-module, rr_picker: inputs req vector and pointer; outputs one-hot grant and encoded index. Purely combinational; instantiated for both policies, with the pointer tied to 0 under fixed priority.

Test Plan:
- Single master: master 1 requests addr 0x8000_0010 -> s_arvalid at t+1 with s_araddr=0x8000_0010, s_arid=2. With s_arready=1, m_arready[1] pulses one cycle. A 4-beat burst reaches only m_rvalid[1].
- Simultaneous requests: masters 0 and 1 request together.
  - With RR defined: grants alternate 0,1,0,1 over four back-to-back bursts.
  - Without RR: master 0 always wins while it keeps requesting.
- Backpressure: s_arready held low 5 cycles -> s_arvalid/addr/id stable all 5 cycles. m_rready[g] low mid-burst -> s_rready low and the beat is held.
- ID mismatch: slave returns s_rid=3 for a grant expecting 1 -> id_err=1 and stays set until rst; the data still reaches master 0.
- Reset mid-burst: rst asserted in DATA after beat 2 of 4 -> next cycle all outputs 0 and state IDLE; a new request is served normally.
- Wrap-around: N_MASTERS=4 with all masters requesting continuously -> RR grant order 0,1,2,3,0.
